timer_mmss_ctrl: RTL and testbench
==================================

Name: timer_mmss_ctrl

Overview:
Parametrised successor of the single-shot minute/second timer. Counts in MM:SS with a built-in prescaler, selectable up/down mode, pause/resume and clear. Preset is captured at start. Sits between the front-panel input logic (switches, debounced keys) and the 7-segment/display driver plus alarm logic.

Parameters:
MIN_W, 6, width of minute field (max minute = 2**MIN_W-1)
TICK_DIV, 50000000, SYSCLK cycles per counted second (must be >= 2)
SEC_MAX, 59, last second value before wrap

Ports:
SYSCLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous, active-high reset
TIME_MIN  input  MIN_W  preset minutes
TIME_SEC  input  6  preset seconds; values > SEC_MAX are clamped to SEC_MAX at capture
MODE_DOWN  input  1  0 = count up from 00:00 to preset, 1 = count down from preset to 00:00; sampled at START
START  input  1  one-cycle start/restart request
PAUSE  input  1  level; high holds the count
CLEAR  input  1  one-cycle abort; returns to IDLE and zeroes display
MINUTE  output  MIN_W  current minute value
SECOND  output  6  current second value
TICK  output  1  one-cycle pulse per counted second (RUN only)
RUNNING  output  1  high in RUN or HOLD
TIME_UP  output  1  one-cycle pulse on expiry
EXPIRED  output  1  level, set on expiry, cleared by START or CLEAR

Behaviour:
- Reset: state IDLE, MINUTE=0, SECOND=0, prescaler=0, TICK=0, RUNNING=0, TIME_UP=0, EXPIRED=0. All outputs are registered.
- States: IDLE, RUN, HOLD, DONE.
- Priority when inputs coincide: CLEAR > START > PAUSE.
- CLEAR in any state: next state IDLE, MINUTE/SECOND=0, prescaler=0, EXPIRED=0.
- START in any state:
  - Captures the preset into target registers (PM, PS) and captures MODE_DOWN.
  - Clears the prescaler and EXPIRED.
  - Loads MINUTE:SECOND = PM:PS in down mode, 00:00 in up mode.
  - If the captured preset is 00:00, next state is DONE. Otherwise next state is RUN. START during RUN/HOLD is therefore a restart.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps. On the cycle it equals TICK_DIV-1, one tick occurs: TICK=1 next cycle and the count updates.
  - Up-mode update: SECOND+1; if SECOND==SEC_MAX, SECOND=0 and MINUTE+1.
  - Down-mode update: SECOND-1; if SECOND==0, SECOND=SEC_MAX and MINUTE-1.
  - Expiry: when the updated value equals the target (PM:PS up, 00:00 down), the same edge that writes the value moves the state to DONE.
  - PAUSE=1 (without a tick due) -> HOLD. If a tick and PAUSE coincide, the tick is applied first, then the state moves to HOLD.
- HOLD: prescaler, MINUTE and SECOND frozen; TICK=0. PAUSE=0 -> RUN, and the prescaler resumes from its held value.
- DONE: lasts exactly one cycle. TIME_UP=1 and EXPIRED set during it. Next state is IDLE; MINUTE:SECOND keep the final value.
- IDLE: counters frozen; RUNNING=0; display holds the last value until START or CLEAR.
- Minute overflow in up mode is impossible, because the target is at most max minute. The minute field wraps modulo 2**MIN_W only if the target logic is bypassed; this is not permitted.
- Latency: START at edge k gives RUNNING=1 after edge k. The first count change is TICK_DIV cycles later. An N-second run asserts TIME_UP N*TICK_DIV+1 cycles after the START edge.
- Preset inputs changing while RUN/HOLD have no effect.
- Asserting RST mid-run returns immediately (asynchronously) to the reset values.

Decomposition:
- Package timer_pkg:
  - state enum (IDLE, RUN, HOLD, DONE)
  - SEC_W=6
  - default SEC_MAX
  - clamp function for the seconds preset
- One sub-module, timer_prescaler:
  - parameter TICK_DIV
  - inputs: enable, clear
  - output: tick pulse
  - width $clog2(TICK_DIV)
- Top-level contents: the FSM, the MM:SS counter and the output registers.

Test Plan:
- TICK_DIV=4, up mode, preset 00:03, START pulse -> SECOND steps 1,2,3 every 4 cycles; TIME_UP one-cycle pulse 13 cycles after START; EXPIRED stays 1; state returns to IDLE.
- Down mode, preset 01:00 -> after first tick MINUTE=0, SECOND=59; TIME_UP after 60 ticks with display 00:00.
- Preset 00:00 with START -> TIME_UP pulse 1 cycle after START, RUNNING never high, EXPIRED=1.
- PAUSE high for 10 cycles mid-run after 2 prescaler counts -> no TICK during HOLD; next tick arrives 2 cycles after PAUSE falls; total run time extended by exactly 10 cycles.
- START and CLEAR on the same cycle during RUN -> IDLE, 00:00, no TIME_UP; then START alone with TIME_SEC=63 -> captured target 59.
- RST asserted mid-run at 00:02 -> all outputs 0 immediately; after release, the count does not resume without START.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and helpers for the MM:SS timer.
// Seconds field width and the preset clamp live here.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  localparam int SEC_W = 6;
  localparam int SEC_MAX_DEF = 59;

  function automatic logic [SEC_W-1:0] sec_clamp(
    input logic [SEC_W-1:0] s,
    input logic [SEC_W-1:0] smax
  );
    return (s > smax) ? smax : s;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides SYSCLK down to one tick per counted second.
// Count holds while disabled so a paused run resumes mid-second.
module timer_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic SYSCLK,
  input  logic RST,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/timer_mmss_ctrl.sv
// MM:SS up/down timer with pause, clear and expiry flags.
// Preset and direction are frozen at START.
module timer_mmss_ctrl
  import timer_pkg::*;
#(
  parameter int MIN_W = 6,
  parameter int TICK_DIV = 50000000,
  parameter int SEC_MAX = SEC_MAX_DEF
) (
  input  logic             SYSCLK,
  input  logic             RST,
  input  logic [MIN_W-1:0] TIME_MIN,
  input  logic [SEC_W-1:0] TIME_SEC,
  input  logic             MODE_DOWN,
  input  logic             START,
  input  logic             PAUSE,
  input  logic             CLEAR,
  output logic [MIN_W-1:0] MINUTE,
  output logic [SEC_W-1:0] SECOND,
  output logic             TICK,
  output logic             RUNNING,
  output logic             TIME_UP,
  output logic             EXPIRED
);

  localparam logic [SEC_W-1:0] SMAX = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0] S1 = SEC_W'(1);
  localparam logic [MIN_W-1:0] M1 = MIN_W'(1);

  state_t           state;
  logic [MIN_W-1:0] pm;
  logic [SEC_W-1:0] ps;
  logic             down_q;
  logic             tick;
  logic [SEC_W-1:0] ps_cap;
  logic             preset_zero;
  logic [MIN_W-1:0] nxt_min;
  logic [SEC_W-1:0] nxt_sec;
  logic             at_target;

  timer_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .SYSCLK(SYSCLK),
    .RST   (RST),
    .enable(state == RUN),
    .clear (CLEAR | START),
    .tick  (tick)
  );

  assign ps_cap = sec_clamp(TIME_SEC, SMAX);
  assign preset_zero = (TIME_MIN == '0) && (ps_cap == '0);

  always_comb begin
    nxt_min = MINUTE;
    nxt_sec = SECOND;
    if (down_q) begin
      if (SECOND == '0) begin
        nxt_sec = SMAX;
        nxt_min = MINUTE - M1;
      end else begin
        nxt_sec = SECOND - S1;
      end
    end else begin
      if (SECOND == SMAX) begin
        nxt_sec = '0;
        nxt_min = MINUTE + M1;
      end else begin
        nxt_sec = SECOND + S1;
      end
    end
    at_target = down_q ? (nxt_min == '0 && nxt_sec == '0)
                       : (nxt_min == pm && nxt_sec == ps);
  end

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      pm      <= '0;
      ps      <= '0;
      down_q  <= 1'b0;
      MINUTE  <= '0;
      SECOND  <= '0;
      TICK    <= 1'b0;
      RUNNING <= 1'b0;
      TIME_UP <= 1'b0;
      EXPIRED <= 1'b0;
    end else begin
      TICK    <= 1'b0;
      TIME_UP <= 1'b0;
      if (CLEAR) begin
        state   <= IDLE;
        MINUTE  <= '0;
        SECOND  <= '0;
        RUNNING <= 1'b0;
        EXPIRED <= 1'b0;
      end else if (START) begin
        pm      <= TIME_MIN;
        ps      <= ps_cap;
        down_q  <= MODE_DOWN;
        EXPIRED <= 1'b0;
        MINUTE  <= MODE_DOWN ? TIME_MIN : '0;
        SECOND  <= MODE_DOWN ? ps_cap : '0;
        state   <= preset_zero ? DONE : RUN;
        RUNNING <= !preset_zero;
      end else begin
        unique case (state)
          RUN: begin
            if (tick) begin
              TICK   <= 1'b1;
              MINUTE <= nxt_min;
              SECOND <= nxt_sec;
            end
            // a tick landing with PAUSE is applied before holding
            if (tick && at_target) begin
              state   <= DONE;
              RUNNING <= 1'b0;
            end else if (PAUSE) begin
              state <= HOLD;
            end
          end
          HOLD: begin
            if (!PAUSE) state <= RUN;
          end
          DONE: begin
            state   <= IDLE;
            TIME_UP <= 1'b1;
            EXPIRED <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_mmss_ctrl.sv
// Table-driven bench for timer_mmss_ctrl with a per-tick scoreboard.
// Expected display values come from a total-seconds model.
module tb_timer_mmss_ctrl;

  localparam int TD = 4;
  localparam int MW = 6;

  logic          SYSCLK = 1'b0;
  logic          RST;
  logic [MW-1:0] TIME_MIN;
  logic [5:0]    TIME_SEC;
  logic          MODE_DOWN;
  logic          START;
  logic          PAUSE;
  logic          CLEAR;
  logic [MW-1:0] MINUTE;
  logic [5:0]    SECOND;
  logic          TICK;
  logic          RUNNING;
  logic          TIME_UP;
  logic          EXPIRED;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int m;
    int s;
    bit down;
    int pa;
    int pl;
    int fm;
    int fs;
    int up_at;
  } vec_t;

  typedef struct {
    int m;
    int s;
  } mmss_t;

  mmss_t exp_q[$];
  vec_t  vecs[8];

  timer_mmss_ctrl #(
    .MIN_W   (MW),
    .TICK_DIV(TD),
    .SEC_MAX (59)
  ) dut (
    .SYSCLK   (SYSCLK),
    .RST      (RST),
    .TIME_MIN (TIME_MIN),
    .TIME_SEC (TIME_SEC),
    .MODE_DOWN(MODE_DOWN),
    .START    (START),
    .PAUSE    (PAUSE),
    .CLEAR    (CLEAR),
    .MINUTE   (MINUTE),
    .SECOND   (SECOND),
    .TICK     (TICK),
    .RUNNING  (RUNNING),
    .TIME_UP  (TIME_UP),
    .EXPIRED  (EXPIRED)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit exp_tick(input int c, input int pa,
                                  input int pl, input int n);
    int e;
    if (pl > 0 && c >= pa + 2 && c <= pa + 1 + pl) return 1'b0;
    e = (pl > 0 && c > pa + 1 + pl) ? c - pl : c;
    return (e > 0) && (e % TD == 0) && (e <= n * TD);
  endfunction

  task automatic do_start(input int m, input int s, input bit d);
    @(negedge SYSCLK);
    TIME_MIN  = MW'(m);
    TIME_SEC  = 6'(s);
    MODE_DOWN = d;
    START     = 1'b1;
    @(negedge SYSCLK);
    START = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int    ps;
    int    tgt;
    int    c;
    bit    seen;
    bit    bad;
    mmss_t e;
    ps  = (v.s > 59) ? 59 : v.s;
    tgt = v.m * 60 + ps;
    exp_q.delete();
    for (int i = 1; i <= tgt; i++) begin
      int t;
      t   = v.down ? tgt - i : i;
      e.m = t / 60;
      e.s = t % 60;
      exp_q.push_back(e);
    end
    do_start(v.m, v.s, v.down);
    chk("running_after_start", int'(RUNNING), int'(tgt > 0));
    chk("expired_after_start", int'(EXPIRED), 0);
    c    = 0;
    seen = 1'b0;
    while (!seen && c < v.up_at + 20) begin
      if (c == v.pa) PAUSE = 1'b1;
      if (c == v.pa + v.pl) PAUSE = 1'b0;
      TIME_MIN  = MW'($urandom);
      TIME_SEC  = 6'($urandom);
      MODE_DOWN = 1'($urandom);
      @(negedge SYSCLK);
      c++;
      chk("tick_timing", int'(TICK), int'(exp_tick(c, v.pa, v.pl, tgt)));
      if (TICK) begin
        if (exp_q.size() == 0) begin
          chk("extra_tick", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("tick_minute", int'(MINUTE), e.m);
          chk("tick_second", int'(SECOND), e.s);
        end
      end
      if (TIME_UP) begin
        seen = 1'b1;
        chk("time_up_cycle", c, v.up_at);
        chk("final_minute", int'(MINUTE), v.fm);
        chk("final_second", int'(SECOND), v.fs);
        chk("expired_at_up", int'(EXPIRED), 1);
        chk("running_at_up", int'(RUNNING), 0);
        chk("ticks_left", exp_q.size(), 0);
      end else begin
        chk("running_level", int'(RUNNING), int'(c < v.up_at - 1));
      end
    end
    if (!seen) chk("time_up_timeout", 0, 1);
    PAUSE = 1'b0;
    @(negedge SYSCLK);
    chk("time_up_one_cycle", int'(TIME_UP), 0);
    chk("expired_held", int'(EXPIRED), 1);
    bad = 1'b0;
    repeat (2 * TD) begin
      @(negedge SYSCLK);
      if (TICK || RUNNING || TIME_UP) bad = 1'b1;
      if (int'(SECOND) != v.fs || int'(MINUTE) != v.fm) bad = 1'b1;
    end
    chk("idle_holds_display", int'(bad), 0);
  endtask

  initial begin
    int c;
    bit seen;
    vecs[0] = '{0, 3, 1'b0, -1, 0, 0, 3, 3 * TD + 1};
    vecs[1] = '{1, 0, 1'b1, -1, 0, 0, 0, 60 * TD + 1};
    vecs[2] = '{0, 0, 1'b0, -1, 0, 0, 0, 1};
    vecs[3] = '{0, 2, 1'b1, -1, 0, 0, 0, 2 * TD + 1};
    vecs[4] = '{1, 1, 1'b0, -1, 0, 1, 1, 61 * TD + 1};
    vecs[5] = '{0, 3, 1'b0, 2, 10, 0, 3, 3 * TD + 1 + 10};
    vecs[6] = '{0, 0, 1'b1, -1, 0, 0, 0, 1};
    vecs[7] = '{0, 63, 1'b0, -1, 0, 0, 59, 59 * TD + 1};

    RST = 1'b1;
    TIME_MIN = '0;
    TIME_SEC = '0;
    MODE_DOWN = 1'b0;
    START = 1'b0;
    PAUSE = 1'b0;
    CLEAR = 1'b0;
    repeat (2) @(negedge SYSCLK);
    chk("rst_minute", int'(MINUTE), 0);
    chk("rst_second", int'(SECOND), 0);
    chk("rst_tick", int'(TICK), 0);
    chk("rst_running", int'(RUNNING), 0);
    chk("rst_time_up", int'(TIME_UP), 0);
    chk("rst_expired", int'(EXPIRED), 0);
    RST = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // START and CLEAR together mid-run: CLEAR wins
    do_start(0, 5, 1'b0);
    repeat (6) @(negedge SYSCLK);
    START = 1'b1;
    CLEAR = 1'b1;
    TIME_SEC = 6'd9;
    @(negedge SYSCLK);
    START = 1'b0;
    CLEAR = 1'b0;
    chk("clr_minute", int'(MINUTE), 0);
    chk("clr_second", int'(SECOND), 0);
    chk("clr_running", int'(RUNNING), 0);
    chk("clr_expired", int'(EXPIRED), 0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge SYSCLK);
      if (TIME_UP || TICK || RUNNING) seen = 1'b1;
    end
    chk("clr_stays_idle", int'(seen), 0);

    run_vec(vecs[7]);

    // CLEAR after expiry drops EXPIRED and zeroes the display
    @(negedge SYSCLK);
    CLEAR = 1'b1;
    @(negedge SYSCLK);
    CLEAR = 1'b0;
    chk("clear_expired", int'(EXPIRED), 0);
    chk("clear_second", int'(SECOND), 0);

    // asynchronous reset mid-run
    do_start(0, 5, 1'b0);
    c = 0;
    while (SECOND != 6'd2 && c < 20) begin
      @(negedge SYSCLK);
      c++;
    end
    chk("reached_0002", int'(SECOND), 2);
    #2 RST = 1'b1;
    #1;
    chk("arst_second", int'(SECOND), 0);
    chk("arst_running", int'(RUNNING), 0);
    chk("arst_tick", int'(TICK), 0);
    chk("arst_expired", int'(EXPIRED), 0);
    @(negedge SYSCLK);
    RST = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge SYSCLK);
      if (TICK || RUNNING || TIME_UP || SECOND != '0) seen = 1'b1;
    end
    chk("no_resume_after_rst", int'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
